// File: rtl/pg_pkg.sv
// Constants shared by the pg02 pulse generator and the pulse analyser:
// counter widths, default loss-of-signal limit and analyser FSM encoding.
package pg_pkg;

  localparam int PG_CNT_W          = 27;
  localparam int PG_PCNT_W         = 8;
  localparam int PG_SYNC_STAGES    = 2;
  localparam int PG_TIMEOUT_CYCLES = 100000000;

  typedef logic [1:0] pa_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

endpackage

// File: rtl/pulse_analyser_if.sv
// Measurement bus of the pulse analyser: control/input side driven by the
// master, results and strobes driven by the analyser (slave).
interface pulse_analyser_if #(
  parameter int CNT_W  = 27,
  parameter int PCNT_W = 8
);

  // Strobes are valid-only: meas_valid/cycle_done are one-clk pulses with no
  // ready; the consumer must take high_time/period/pulse_count in that clk or
  // later (they hold until the next strobe). timeout/overflow are levels.
  logic              enable;
  logic              signal_in;
  logic              cycle_in;
  logic [CNT_W-1:0]  high_time;
  logic [CNT_W-1:0]  period;
  logic [PCNT_W-1:0] pulse_count;
  logic              meas_valid;
  logic              cycle_done;
  logic              timeout;
  logic              overflow;
  logic [1:0]        dbg_state;

  modport master (
    output enable, signal_in, cycle_in,
    input  high_time, period, pulse_count, meas_valid, cycle_done,
           timeout, overflow, dbg_state
  );

  modport slave (
    input  enable, signal_in, cycle_in,
    output high_time, period, pulse_count, meas_valid, cycle_done,
           timeout, overflow, dbg_state
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with registered
// rise/fall pulses; input change to pulse takes SYNC_STAGES+1 clks.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_q_d;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
      r_q_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_q_d  <= w_s;
      r_rise <= w_s & ~r_q_d;
      r_fall <= ~w_s & r_q_d;
    end
  end

  assign q    = w_s;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/pulse_analyser.sv
// Measures high time, period and pulses-per-cycle of an external pulse train
// (signal_in) framed by a cycle marker (cycle_in), all in clk counts.
module pulse_analyser
  import pg_pkg::*;
#(
  parameter int CNT_W          = PG_CNT_W,
  parameter int PCNT_W         = PG_PCNT_W,
  parameter int SYNC_STAGES    = PG_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = PG_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  pulse_analyser_if.slave  bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pulse_analyser: SYNC_STAGES must be at least 2");
  end
  if (64'(TIMEOUT_CYCLES) >= ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
    $error("pulse_analyser: TIMEOUT_CYCLES must be below 2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  logic w_sig_q, w_sig_rise, w_sig_fall;
  logic w_cyc_q, w_cyc_rise, w_cyc_fall;
  logic w_unused_sync;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
    .clk(clk), .reset(reset), .d(bus.signal_in),
    .q(w_sig_q), .rise(w_sig_rise), .fall(w_sig_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cyc_sync (
    .clk(clk), .reset(reset), .d(bus.cycle_in),
    .q(w_cyc_q), .rise(w_cyc_rise), .fall(w_cyc_fall)
  );

  assign w_unused_sync = &{1'b0, w_sig_q, w_cyc_q, w_cyc_fall};

  pa_state_t         r_state;
  logic [CNT_W-1:0]  r_per_cnt, r_hi_cnt, r_high_time, r_period;
  logic [PCNT_W-1:0] r_pcnt, r_pulse_count;
  logic              r_meas_valid, r_cycle_done, r_timeout, r_overflow;
  logic              r_cyc_armed;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_per_cnt     <= '0;
      r_hi_cnt      <= '0;
      r_high_time   <= '0;
      r_period      <= '0;
      r_pcnt        <= '0;
      r_pulse_count <= '0;
      r_meas_valid  <= 1'b0;
      r_cycle_done  <= 1'b0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_cyc_armed   <= 1'b0;
    end else if (!bus.enable) begin
      r_state      <= ST_IDLE;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_pcnt       <= '0;
      r_meas_valid <= 1'b0;
      r_cycle_done <= 1'b0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_cyc_armed  <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_cycle_done <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_ARM;
        ST_ARM: begin
          if (w_sig_rise) begin
            r_state   <= ST_HIGH;
            r_per_cnt <= CNT_W'(1);
            r_hi_cnt  <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (r_per_cnt == TO_VAL) begin
            r_state   <= ST_ARM;
            r_timeout <= 1'b1;
          end else begin
            r_per_cnt <= r_per_cnt + CNT_W'(1);
            // The falling-edge clk already belongs to the low phase.
            if (w_sig_fall) r_state  <= ST_LOW;
            else            r_hi_cnt <= r_hi_cnt + CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (r_per_cnt == TO_VAL) begin
            r_state   <= ST_ARM;
            r_timeout <= 1'b1;
          end else if (w_sig_rise) begin
            r_period     <= r_per_cnt;
            r_high_time  <= r_hi_cnt;
            r_meas_valid <= 1'b1;
            r_timeout    <= 1'b0;
            r_per_cnt    <= CNT_W'(1);
            r_hi_cnt     <= CNT_W'(1);
            r_state      <= ST_HIGH;
          end else begin
            r_per_cnt <= r_per_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A signal rise coinciding with the marker is the first pulse of the new cycle.
      if (w_cyc_rise) begin
        r_cyc_armed <= 1'b1;
        if (r_cyc_armed) begin
          r_pulse_count <= r_pcnt;
          r_cycle_done  <= 1'b1;
        end
        r_pcnt <= w_sig_rise ? PCNT_W'(1) : '0;
      end else if (w_sig_rise) begin
        if (r_pcnt == PCNT_MAX) r_overflow <= 1'b1;
        else                    r_pcnt     <= r_pcnt + PCNT_W'(1);
      end
    end
  end

  assign bus.high_time   = r_high_time;
  assign bus.period      = r_period;
  assign bus.pulse_count = r_pulse_count;
  assign bus.meas_valid  = r_meas_valid & bus.enable & reset;
  assign bus.cycle_done  = r_cycle_done & bus.enable & reset;
  assign bus.timeout     = r_timeout;
  assign bus.overflow    = r_overflow;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_pulse_analyser.sv
// Directed bench for pulse_analyser: stimulus pushes expected strobe payloads,
// a negedge monitor pops and compares them whenever a strobe appears.
module tb_pulse_analyser;
  import pg_pkg::*;

  localparam int CW = 16;
  localparam int PW = 4;
  localparam int SS = 2;
  localparam int TO = 50;

  logic clk;
  logic reset;

  pulse_analyser_if #(.CNT_W(CW), .PCNT_W(PW)) bus ();

  pulse_analyser #(
    .CNT_W(CW), .PCNT_W(PW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [2*CW-1:0] meas_exp_q[$];
  logic [PW-1:0]   cyc_exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      logic [2*CW-1:0] exp_m;
      n_checks++;
      if (meas_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL meas_unexpected: high_time=%0d period=%0d, expected no strobe",
                 bus.high_time, bus.period);
      end else begin
        exp_m = meas_exp_q.pop_front();
        if ({bus.high_time, bus.period} !== exp_m) begin
          n_fail++;
          $display("FAIL meas: high_time=%0d period=%0d, expected high_time=%0d period=%0d",
                   bus.high_time, bus.period, exp_m[2*CW-1:CW], exp_m[CW-1:0]);
        end
      end
    end
    if (bus.cycle_done === 1'b1) begin
      logic [PW-1:0] exp_c;
      n_checks++;
      if (cyc_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cycle_unexpected: pulse_count=%0d, expected no strobe", bus.pulse_count);
      end else begin
        exp_c = cyc_exp_q.pop_front();
        if (bus.pulse_count !== exp_c) begin
          n_fail++;
          $display("FAIL cycle: pulse_count=%0d, expected %0d", bus.pulse_count, exp_c);
        end
      end
    end
  end

  // driver tasks
  task automatic hold(input logic s, input logic c, input int n);
    bus.signal_in = s;
    bus.cycle_in  = c;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l);
    hold(1'b1, 1'b0, h);
    hold(1'b0, 1'b0, l);
  endtask

  task automatic pulse_c(input int h, input int l);
    hold(1'b1, 1'b1, 1);
    hold(1'b1, 1'b0, h - 1);
    hold(1'b0, 1'b0, l);
  endtask

  task automatic restart();
    bus.enable = 1'b0;
    hold(1'b0, 1'b0, 2);
    bus.enable = 1'b1;
    hold(1'b0, 1'b0, 3);
  endtask

  int lat;
  int first_to;
  bit found;

  initial begin
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.signal_in = 1'b0;
    bus.cycle_in = 1'b0;
    hold(1'b0, 1'b0, 3);
    @(negedge clk);
    check("rst_high_time", 32'(bus.high_time), 0);
    check("rst_period", 32'(bus.period), 0);
    check("rst_pulse_count", 32'(bus.pulse_count), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    hold(1'b0, 1'b0, 2);

    // square wave H=5 L=7
    bus.enable = 1'b1;
    hold(1'b0, 1'b0, 4);
    repeat (4) meas_exp_q.push_back({16'd5, 16'd12});
    pulse(5, 7);
    bus.signal_in = 1'b1;
    lat = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.meas_valid) found = 1;
    end
    check("first_meas_latency", 32'(lat), 32'(SS + 2));
    @(posedge clk);
    #1;
    hold(1'b0, 1'b0, 7);
    repeat (3) pulse(5, 7);
    hold(1'b0, 1'b0, 2);
    check("sq_high_time", 32'(bus.high_time), 5);
    check("sq_period", 32'(bus.period), 12);

    // four pulses per cycle, marker on the fifth rise
    restart();
    repeat (12) meas_exp_q.push_back({16'd2, 16'd4});
    repeat (3) cyc_exp_q.push_back(4'd4);
    for (int c = 0; c < 3; c++) begin
      pulse_c(2, 2);
      repeat (3) pulse(2, 2);
    end
    pulse_c(2, 2);
    hold(1'b0, 1'b0, 4);
    check("cyc_pulse_count", 32'(bus.pulse_count), 4);

    // loss of signal
    restart();
    bus.signal_in = 1'b1;
    first_to = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) bus.signal_in = 1'b0;
      @(negedge clk);
      if (bus.timeout && first_to == 0) first_to = i;
    end
    check("timeout_latency", 32'(first_to), 32'(SS + 2 + TO));
    check("timeout_state_arm", 32'(bus.dbg_state), 32'(ST_ARM));
    check("timeout_no_update", 32'(bus.period), 4);
    repeat (2) meas_exp_q.push_back({16'd3, 16'd6});
    pulse(3, 3);
    check("timeout_held", 32'(bus.timeout), 1);
    repeat (2) pulse(3, 3);
    hold(1'b0, 1'b0, 4);
    check("timeout_cleared", 32'(bus.timeout), 0);

    // pulse counter saturation
    restart();
    repeat (20) meas_exp_q.push_back({16'd2, 16'd4});
    cyc_exp_q.push_back(4'd15);
    pulse_c(2, 2);
    repeat (19) pulse(2, 2);
    pulse_c(2, 2);
    hold(1'b0, 1'b0, 4);
    check("ovf_set", 32'(bus.overflow), 1);
    check("ovf_pulse_count", 32'(bus.pulse_count), 15);
    hold(1'b0, 1'b0, 6);
    check("ovf_sticky", 32'(bus.overflow), 1);
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    bus.enable = 1'b1;
    @(negedge clk);
    check("ovf_cleared", 32'(bus.overflow), 0);
    check("ovf_count_held", 32'(bus.pulse_count), 15);
    hold(1'b0, 1'b0, 3);

    // reset mid pulse train
    hold(1'b1, 1'b0, 2);
    reset = 1'b0;
    hold(1'b1, 1'b0, 1);
    hold(1'b0, 1'b0, 2);
    @(negedge clk);
    check("mid_rst_high_time", 32'(bus.high_time), 0);
    check("mid_rst_period", 32'(bus.period), 0);
    check("mid_rst_pulse_count", 32'(bus.pulse_count), 0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    hold(1'b0, 1'b0, 4);
    repeat (2) meas_exp_q.push_back({16'd3, 16'd7});
    pulse(3, 4);
    check("mid_rst_no_early_meas", 32'(meas_exp_q.size()), 2);
    repeat (2) pulse(3, 4);
    hold(1'b0, 1'b0, 4);

    // enable dropped during HIGH
    restart();
    repeat (3) meas_exp_q.push_back({16'd4, 16'd9});
    repeat (3) pulse(4, 5);
    hold(1'b1, 1'b0, 6);
    @(negedge clk);
    check("drop_state_high", 32'(bus.dbg_state), 32'(ST_HIGH));
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drop_state_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("drop_high_time", 32'(bus.high_time), 4);
    check("drop_period", 32'(bus.period), 9);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 5);

    check("meas_queue_empty", 32'(meas_exp_q.size()), 0);
    check("cyc_queue_empty", 32'(cyc_exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_analyser.md
Name: pulse_analyser

Overview:
- Receive-side counterpart of the pg02 pulse generator; measures the signal_out/signal_cycle pair that the generator drives on ja0/ja1.
- Synchronises both asynchronous inputs.
- Reports high time, period and pulses-per-cycle in clk counts.
- Sits inside the board wrapper beside pg02 for loopback self-test, or on a second board to characterise an external generator.

Parameters:
- CNT_W, 27, width of the high_time/period counters.
- PCNT_W, 8, width of the pulse-per-cycle counter.
- SYNC_STAGES, 2, flops in each input synchroniser (minimum 2).
- TIMEOUT_CYCLES, 100000000, period-counter value that declares loss of signal. Must be less than 2^CNT_W-1; elaboration error otherwise.

Ports:
- clk  input  1  system clock (100 MHz in the wrapper)
- reset  input  1  synchronous, active-low reset; reset==0 clears all state on the next clk edge
- enable  input  1  1 = measure; 0 = return to IDLE
- signal_in  input  1  asynchronous pulse train
- cycle_in  input  1  asynchronous cycle marker
- high_time  output  CNT_W  high duration of last complete pulse
- period  output  CNT_W  rise-to-rise duration of last complete pulse
- pulse_count  output  PCNT_W  pulses counted in last complete cycle
- meas_valid  output  1  one-clk strobe; high_time/period updated
- cycle_done  output  1  one-clk strobe; pulse_count updated
- timeout  output  1  level; no rising edge for TIMEOUT_CYCLES
- overflow  output  1  sticky; pulse counter saturated

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0.
  - FSM goes to IDLE, all counters and synchroniser flops go to 0.
  - Reset dominates enable and all edges.
- Edge detection on synchronised s:
  - rise = s & ~s_d; fall = ~s & s_d.
  - Input transition to rise/fall asserted takes SYNC_STAGES+1 clks.
- FSM IDLE:
  - enable=0: counters held at 0.
  - Outputs high_time, period and pulse_count hold their last values.
  - overflow clears.
  - enable=1 goes to ARM next clk.
- FSM ARM (wait for first rise; a pulse already in progress is ignored):
  - rise: go to HIGH; per_cnt<=1, hi_cnt<=1.
- FSM HIGH:
  - per_cnt and hi_cnt increment each clk.
  - fall: go to LOW; hi_cnt frozen.
- FSM LOW:
  - per_cnt increments each clk.
  - rise: period<=per_cnt, high_time<=hi_cnt; meas_valid=1 on the following clk.
  - Then timeout<=0, per_cnt<=1, hi_cnt<=1, go to HIGH.
- Result: a waveform high H clks, low L clks gives high_time=H, period=H+L, exactly.
- Timeout:
  - In HIGH or LOW, per_cnt==TIMEOUT_CYCLES forces ARM and sets timeout=1.
  - high_time and period are not updated.
  - timeout clears on the next meas_valid, on reset, or on enable=0.
- enable falling in any state:
  - IDLE next clk; no strobe for a partial measurement.
- Pulse counting:
  - pcnt increments on every signal rise while enable=1.
  - pcnt saturates at 2^PCNT_W-1 and sets overflow.
- Cycle marker (cycle_in rise while enable=1):
  - pulse_count<=pcnt, cycle_done=1 for one clk, pcnt<=0.
  - The first cycle marker after enable only starts counting: pcnt cleared, no cycle_done.
- Simultaneous signal rise and cycle rise:
  - The pulse belongs to the new cycle: pulse_count<=pcnt (excluding it), pcnt<=1.
- meas_valid and cycle_done may assert in the same clk.
- Strobes never assert while reset==0 or enable==0.

Decomposition:
- Shared package pg_pkg: FSM state encoding (IDLE, ARM, HIGH, LOW), default TIMEOUT_CYCLES, counter width constants shared with pg02.
- One sub-module sync_edge (parameter SYNC_STAGES; ports clk, reset, d, q, rise, fall), instantiated twice: signal_in and cycle_in.

Test Plan:
1. reset=0 for 3 clks mid-pulse-train -> all outputs 0; after release with enable=1, first meas_valid only after two full rises.
2. Square wave H=5 L=7, enable=1 -> meas_valid every 12 clks with high_time=5, period=12. First strobe is SYNC_STAGES+2 clks after the second input rise.
3. Four pulses (H=2 L=2), then cycle_in rising together with the fifth rise, repeated -> cycle_done one clk, pulse_count=4; the next cycle also reports 4.
4. TIMEOUT_CYCLES=50, one rise, then signal held low 60 clks -> timeout=1 exactly 50 clks after the latched rise, FSM in ARM. Then H=3 L=3 pulses -> meas_valid with period=6, timeout=0.
5. PCNT_W=4, 20 pulses between cycle markers -> pulse_count=15, overflow=1 stays set. enable=0 for one clk clears overflow; pulse_count holds 15.
6. enable dropped during HIGH -> FSM IDLE next clk, no meas_valid, high_time/period unchanged from the previous measurement.
